// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, sequencer states and sizing shared by the RV32M multiply/divide sequencer.
package muldiv_pkg;
    localparam int MD_XLEN = 32;
    localparam int MD_ITER = MD_XLEN;
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t;
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result handshake bundle between execute (master) and the muldiv sequencer (slave).
interface muldiv_if import muldiv_pkg::*; #(parameter int XLEN = MD_XLEN);
    logic            i_valid, o_ready, i_flush, o_valid, i_ready, o_busy;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_A, i_B, o_out;
    modport master (output i_valid, i_op, i_A, i_B, i_flush, i_ready,
                    input  o_ready, o_valid, o_out, o_busy);
    modport slave  (input  i_valid, i_op, i_A, i_B, i_flush, i_ready,
                    output o_ready, o_valid, o_out, o_busy);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration; shift/add multiply or restoring trial-subtract divide.
module muldiv_step import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   mcand,
    output logic [2*XLEN-1:0] acc_nxt
);
    logic [XLEN:0] sum, diff;
    logic          keep;
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        // a shifted-out remainder MSB means the partial remainder already exceeds any divisor
        diff    = acc[2*XLEN-1:XLEN-1] - {1'b0, mcand};
        keep    = acc[2*XLEN-1] | !diff[XLEN];
        acc_nxt = is_div ? (keep ? {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0})
                         : {sum, acc[XLEN-1:1]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer with valid/ready result handshake.
// MULDIV_FAST_PATH_EN retires zero-operand multiplies, divide-by-zero and signed overflow straight from IDLE.
module muldiv_seq import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN
) (
    input logic     i_clk,
    input logic     i_rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(MD_ITER);
    md_state_t         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
    logic [XLEN-1:0]   mcand_q, mcand_d, out_q, out_d, mag_a, mag_b, word;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d, sa, sb, is_div;
`ifdef MULDIV_FAST_PATH_EN
    logic              fast;
    logic [XLEN-1:0]   fast_res;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (md_is_div(op_q)),
        .acc    (acc_q),
        .mcand  (mcand_q),
        .acc_nxt(acc_step)
    );

    always_comb begin
        is_div  = md_is_div(bus.i_op);
        sa      = bus.i_A[XLEN-1] & (bus.i_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        sb      = bus.i_B[XLEN-1] & (bus.i_op inside {MD_MULH, MD_DIV, MD_REM});
        mag_a   = sa ? -bus.i_A : bus.i_A;
        mag_b   = sb ? -bus.i_B : bus.i_B;
        prod    = neg_q ? -acc_q : acc_q;
        word    = md_is_div(op_q) ? (op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0])
                                  : (op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        out_d   = out_q;
`ifdef MULDIV_FAST_PATH_EN
        fast     = !is_div ? (bus.i_A == '0 || bus.i_B == '0)
                           : (bus.i_B == '0 || (!bus.i_op[0] && bus.i_A == {1'b1, {(XLEN-1){1'b0}}} && &bus.i_B));
        fast_res = !is_div ? '0 : bus.i_B == '0 ? (bus.i_op[1] ? bus.i_A : '1) : (bus.i_op[1] ? '0 : bus.i_A);
`endif
        case (state_q)
            IDLE: if (bus.i_valid) begin
                op_d    = bus.i_op;
                // divide-by-zero quotient stays all-ones, so its sign is never applied
                neg_d   = (bus.i_op[2] & bus.i_op[1]) ? sa : (sa ^ sb) & (!is_div | (|bus.i_B));
                acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                mcand_d = is_div ? mag_b : mag_a;
                cnt_d   = CW'(MD_ITER - 1);
                state_d = CALC;
`ifdef MULDIV_FAST_PATH_EN
                if (fast) begin
                    out_d   = fast_res;
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                acc_d   = acc_step;
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == '0 ? FIX : CALC;
            end
            FIX: begin
                out_d   = (md_is_div(op_q) & neg_q) ? -word : word;
                state_d = DONE;
            end
            default: state_d = bus.i_ready ? IDLE : DONE;
        endcase
        if (bus.i_flush) begin
            state_d = IDLE;
            out_d   = out_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            out_q   <= out_d;
        end

    assign bus.o_ready = state_q == IDLE;
    assign bus.o_busy  = state_q != IDLE;
    assign bus.o_valid = state_q == DONE;
    assign bus.o_out   = out_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with hand-computed results for muldiv_seq, default or MULDIV_FAST_PATH_EN build.
module tb_muldiv_seq;
    import muldiv_pkg::*;
    localparam int FULL = 34;
`ifdef MULDIV_FAST_PATH_EN
    localparam int SPEC = 1;
`else
    localparam int SPEC = FULL;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   n;

    muldiv_if bus ();
    muldiv_seq dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold);
        int k = 1;
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_A     = a;
        bus.i_B     = b;
        tick();
        bus.i_valid = 1'b0;
        bus.i_op    = 3'($urandom_range(0, 7));
        bus.i_A     = $urandom;
        bus.i_B     = $urandom;
        while (!bus.o_valid && k < 100) begin
            tick();
            k++;
        end
        chk({tag, " lat"}, k, lat);
        chk({tag, " out"}, bus.o_out, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold_vld"}, bus.o_valid, 1);
            chk({tag, " hold_out"}, bus.o_out, exp);
        end
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk({tag, " vld_drop"}, bus.o_valid, 0);
        chk({tag, " rdy"}, bus.o_ready, 1);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_op    = '0;
        bus.i_A     = '0;
        bus.i_B     = '0;
        #12;
        chk("rst_vld", bus.o_valid, 0);
        chk("rst_out", bus.o_out, 0);
        chk("rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        tick();
        chk("rst_rdy", bus.o_ready, 1);

        run("mul",      MD_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, FULL, 0);
        run("mulhu",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL, 0);
        run("mulh",     MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, FULL, 0);
        run("mulhsu",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, FULL, 0);
        run("mulh_min", MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, FULL, 0);
        run("mul_zero", MD_MUL,    32'h00000000, 32'h00012345, 32'h00000000, SPEC, 0);
        run("div",      MD_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, FULL, 0);
        run("rem",      MD_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, FULL, 0);
        run("divu",     MD_DIVU,   32'd100,      32'd7,        32'd14,       FULL, 0);
        run("remu",     MD_REMU,   32'd100,      32'd7,        32'd2,        FULL, 0);
        run("div_z",    MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPEC, 0);
        run("remu_z",   MD_REMU,   32'd5,        32'd0,        32'd5,        SPEC, 0);
        run("divn_z",   MD_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPEC, 0);
        run("remn_z",   MD_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SPEC, 0);
        run("div_ovf",  MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC, 0);
        run("rem_ovf",  MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPEC, 0);
        run("bp",       MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL, 5);

        bus.i_valid = 1'b1;
        bus.i_flush = 1'b1;
        bus.i_op    = MD_DIVU;
        bus.i_A     = 32'd100;
        bus.i_B     = 32'd7;
        tick();
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        chk("flush_acc_busy", bus.o_busy, 0);

        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        repeat (10) tick();
        chk("calc_busy", bus.o_busy, 1);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        chk("flush_busy", bus.o_busy, 0);
        chk("flush_rdy", bus.o_ready, 1);
        n = 0;
        repeat (40) begin
            tick();
            n += int'(bus.o_valid);
        end
        chk("flush_no_vld", n, 0);
        chk("flush_out_kept", bus.o_out, 32'hFFFFFFFE);

        bus.i_valid = 1'b1;
        bus.i_op    = MD_MUL;
        bus.i_A     = 32'd7;
        bus.i_B     = 32'd3;
        tick();
        bus.i_valid = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.o_busy, 0);
        chk("arst_vld", bus.o_valid, 0);
        chk("arst_out", bus.o_out, 0);
        tick();
        rst = 1'b0;
        tick();
        run("divu_after", MD_DIVU, 32'd9, 32'd3, 32'd3, FULL, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Runs a radix-2 shift/add (MUL*) or restoring shift/subtract (DIV*/REM*) datapath for XLEN iterations, then applies sign correction.
- Execute stalls on o_busy and takes the result through a valid/ready handshake.

Parameters:
- XLEN, 32: operand/result width; only 32 is supported in RV32 builds.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  request valid
- o_ready  out  1  sequencer can accept a request (IDLE only)
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_A  in  XLEN  rs1 operand
- i_B  in  XLEN  rs2 operand
- i_flush  in  1  kill any in-flight operation (pipeline flush/trap)
- o_valid  out  1  result valid
- i_ready  in  1  consumer takes result
- o_out  out  XLEN  result
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_valid=0, o_out=0, o_busy=0, o_ready=1 once released; all internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept on i_valid & o_ready & !i_flush.
  - Latch op and the magnitudes of the signed operands per op (MULH: A,B signed; MULHSU: A signed, B unsigned; DIV/REM: both signed).
  - Record result-negate flag: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Load iteration counter = XLEN-1; next state CALC.
- CALC:
  - One iteration per cycle.
  - Multiply: 2*XLEN-bit accumulator; if multiplier LSB, add multiplicand to the upper half; shift right 1.
  - Divide: shift {rem,quot} left 1; trial-subtract divisor from rem (XLEN+1 bits); if non-negative, keep the difference and set quot LSB.
  - Leave after exactly XLEN cycles (counter reaches 0) -> FIX.
- FIX:
  - Apply two's-complement negation per flag.
  - Select result: low word (MUL), high word (MULH/SU/U), quotient, or remainder.
  - Register into o_out; -> DONE.
- DONE:
  - o_valid=1 and o_out held stable until i_ready.
  - On o_valid & i_ready -> IDLE; o_valid falls next cycle.
  - No accept in the same cycle, so back-to-back issue costs one IDLE cycle.
- Latency: request accepted at edge t; o_valid first high after edge t+XLEN+2 (34 cycles for XLEN=32).
- Divide by zero (RISC-V rules, regardless of path):
  - DIV -> 0xFFFFFFFF; DIVU -> 0xFFFFFFFF.
  - REM and REMU -> i_A.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Magnitude of 0x80000000 is held in XLEN bits unsigned (no overflow).
- i_flush:
  - In any state, next state is IDLE and o_valid drops next cycle.
  - Flush beats accept and beats i_ready in the same cycle; no result is produced.
- i_op/i_A/i_B are ignored outside the accept cycle.
- Async reset mid-operation aborts immediately; no partial result appears.

Optional Feature:
- Macro: MULDIV_FAST_PATH_EN.
- Defined:
  - IDLE detects the special cases: multiply with an operand 0, divide by zero, and signed overflow.
  - For these it skips CALC/FIX and goes straight to DONE with the correct result.
  - o_valid is high after edge t+1.
- Undefined: every op takes the full XLEN+2 latency with identical results.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings MD_MUL..MD_REMU (3-bit);
  - state enum md_state_t {IDLE, CALC, FIX, DONE};
  - constant MD_ITER = XLEN.
- Sub-module muldiv_step: combinational single iteration (mul add-shift / div trial-subtract, selected by is_div), instanced once in CALC.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> o_out 0xFFFFFFEB; o_valid exactly 34 cycles after accept.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; with MULDIV_FAST_PATH_EN each completes after edge t+1, without it after 34 cycles.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and o_out stable; i_ready=1 -> IDLE, o_ready=1 next cycle.
- Assert i_flush at CALC cycle 10 -> IDLE next cycle with no o_valid; assert i_rst mid-CALC -> outputs immediately 0; a new DIVU 9/3 afterwards -> 3.
